// File: rtl/ysyx_22040750_axi_pkg.sv
// ============================================================================
// Module   : ysyx_22040750_axi_pkg
// Brief    : Shared FSM encoding, AXI constants and address helper for the
//            cache-line refill master.
// Revision : 1.0  initial release
// ============================================================================
`default_nettype none

package ysyx_22040750_axi_pkg;

   typedef enum logic [1:0] {
      ST_IDLE = 2'd0,
      ST_AR   = 2'd1,
      ST_R    = 2'd2,
      ST_DONE = 2'd3
   } refill_state_e;

   localparam logic [2:0] AXI_SIZE_8B    = 3'b011;
   localparam logic [1:0] AXI_BURST_INCR = 2'b01;

   // Clear the byte-offset bits so the burst starts on a line boundary.
   function automatic logic [31:0] line_align(input logic [31:0] addr, input int ofs_w);
      return addr & ~((32'd1 << ofs_w) - 32'd1);
   endfunction

endpackage

`default_nettype wire

// File: rtl/ysyx_22040750_axi_refill_if.sv
// ============================================================================
// Module   : ysyx_22040750_axi_refill_if
// Brief    : Cache-side request/line signals plus AXI AR/R channel signals
//            of the refill master, with master/slave views.
// Revision : 1.0  initial release
// ============================================================================
`default_nettype none

interface ysyx_22040750_axi_refill_if #(
   parameter int LINE_BEATS = 4
);
   logic                      req_valid;
   logic [31:0]               req_addr;
   logic                      req_ready;
   logic                      done;
   logic [64*LINE_BEATS-1:0]  line_data;
   logic                      err;

   logic [31:0]               araddr;
   logic                      arvalid;
   logic                      arready;
   logic [7:0]                arlen;
   logic [2:0]                arsize;
   logic [63:0]               rdata;
   logic                      rvalid;
   logic                      rlast;
   logic                      rready;

   modport master (
      input  req_valid, req_addr, arready, rdata, rvalid, rlast,
      output req_ready, done, line_data, err, araddr, arvalid, arlen, arsize, rready
   );

   modport slave (
      output req_valid, req_addr, arready, rdata, rvalid, rlast,
      input  req_ready, done, line_data, err, araddr, arvalid, arlen, arsize, rready
   );

endinterface

`default_nettype wire

// File: rtl/ysyx_22040750_refill_linebuf.sv
// ============================================================================
// Module   : ysyx_22040750_refill_linebuf
// Brief    : LINE_BEATS x 64-bit line buffer, one beat written per cycle at
//            the given slot index, whole line presented flat.
// Revision : 1.0  initial release
// ============================================================================
`default_nettype none

module ysyx_22040750_refill_linebuf #(
   parameter int LINE_BEATS = 4,
   parameter int IDX_W      = $clog2(LINE_BEATS)
) (
   input  logic                     clk,
   input  logic                     rst,
   input  logic                     we,
   input  logic [IDX_W-1:0]         idx,
   input  logic [63:0]              wdata,
   output logic [64*LINE_BEATS-1:0] line
);

   logic [63:0] r_slot [LINE_BEATS];

   generate
      for (genvar g = 0; g < LINE_BEATS; g++) begin : g_slot
         always_ff @(posedge clk) begin
            if (rst) begin
               r_slot[g] <= '0;
            end else if (we && (idx == IDX_W'(g))) begin
               r_slot[g] <= wdata;
            end
         end

         assign line[64*g +: 64] = r_slot[g];
      end
   endgenerate

endmodule

`default_nettype wire

// File: rtl/ysyx_22040750_axi_refill.sv
// ============================================================================
// Module   : ysyx_22040750_axi_refill
// Brief    : AXI4 read-burst master refilling one cache line per request.
//            Optional macro YSYX_22040750_RLAST_CHECK_EN enables the sticky
//            rlast/beat-count mismatch flag and drop-until-rlast recovery.
// Revision : 1.0  initial release
// ============================================================================
`default_nettype none

module ysyx_22040750_axi_refill
   import ysyx_22040750_axi_pkg::*;
#(
   parameter int LINE_BEATS = 4,
   parameter int OFS_W      = 5
) (
   input  logic                       I_clk,
   input  logic                       I_rst,
   ysyx_22040750_axi_refill_if.master bus
);

   localparam int               CNT_W       = $clog2(LINE_BEATS);
   localparam logic [CNT_W-1:0] c_last_beat = CNT_W'(LINE_BEATS - 1);

   refill_state_e     r_state;
   refill_state_e     w_state_nxt;
   logic [CNT_W-1:0]  r_cnt;
   logic [31:0]       r_araddr;
   logic              w_req_ready;
   logic              w_arvalid;
   logic              w_rready;
   logic              w_done;
   logic              w_ar_hs;
   logic              w_beat;
   logic              w_wr;
   logic              w_last_slot;

   assign w_ar_hs     = (r_state == ST_AR) && bus.arready;
   assign w_beat      = (r_state == ST_R) && bus.rvalid;
   assign w_last_slot = (r_cnt == c_last_beat);

`ifdef YSYX_22040750_RLAST_CHECK_EN
   logic r_err;
   logic r_drop;
   logic w_err_set;

   // Once the final slot is filled without rlast, remaining beats are dropped.
   assign w_wr      = w_beat && !r_drop;
   assign w_err_set = w_wr && (bus.rlast != w_last_slot);

   always_ff @(posedge I_clk) begin
      if (I_rst) begin
         r_err  <= 1'b0;
         r_drop <= 1'b0;
      end else begin
         if (w_err_set) begin
            r_err <= 1'b1;
         end
         if (w_ar_hs) begin
            r_drop <= 1'b0;
         end else if (w_wr && w_last_slot && !bus.rlast) begin
            r_drop <= 1'b1;
         end
      end
   end

   assign bus.err = r_err;
`else
   assign w_wr    = w_beat;
   assign bus.err = 1'b0;
`endif

   always_ff @(posedge I_clk) begin
      if (I_rst) begin
         r_state <= ST_IDLE;
      end else begin
         r_state <= w_state_nxt;
      end
   end

   // Handshake outputs decode from state only, keeping input-to-output paths registered.
   always_comb begin
      w_state_nxt = r_state;
      w_req_ready = 1'b0;
      w_arvalid   = 1'b0;
      w_rready    = 1'b0;
      w_done      = 1'b0;
      case (r_state)
         ST_IDLE: begin
            w_req_ready = 1'b1;
            if (bus.req_valid) begin
               w_state_nxt = ST_AR;
            end
         end
         ST_AR: begin
            w_arvalid = 1'b1;
            if (bus.arready) begin
               w_state_nxt = ST_R;
            end
         end
         ST_R: begin
            w_rready = 1'b1;
            if (w_beat && bus.rlast) begin
               w_state_nxt = ST_DONE;
            end
         end
         ST_DONE: begin
            w_done      = 1'b1;
            w_state_nxt = ST_IDLE;
         end
         default: begin
            w_state_nxt = ST_IDLE;
         end
      endcase
   end

   always_ff @(posedge I_clk) begin
      if (I_rst) begin
         r_araddr <= '0;
         r_cnt    <= '0;
      end else begin
         if ((r_state == ST_IDLE) && bus.req_valid) begin
            r_araddr <= line_align(bus.req_addr, OFS_W);
         end
         // Counter saturates on the last slot so overrun beats overwrite it.
         if (w_ar_hs) begin
            r_cnt <= '0;
         end else if (w_wr && !w_last_slot) begin
            r_cnt <= r_cnt + 1'b1;
         end
      end
   end

   ysyx_22040750_refill_linebuf #(
      .LINE_BEATS (LINE_BEATS),
      .IDX_W      (CNT_W)
   ) u_linebuf (
      .clk   (I_clk),
      .rst   (I_rst),
      .we    (w_wr),
      .idx   (r_cnt),
      .wdata (bus.rdata),
      .line  (bus.line_data)
   );

   assign bus.req_ready = w_req_ready;
   assign bus.done      = w_done;
   assign bus.araddr    = r_araddr;
   assign bus.arvalid   = w_arvalid;
   assign bus.arlen     = 8'(LINE_BEATS - 1);
   assign bus.arsize    = AXI_SIZE_8B;
   assign bus.rready    = w_rready;

endmodule

`default_nettype wire

// File: tb/tb_ysyx_22040750_axi_refill.sv
// ============================================================================
// Module   : tb_ysyx_22040750_axi_refill
// Brief    : Directed scoreboard bench for the cache-line refill master.
// Revision : 1.0  initial release
// ============================================================================
`default_nettype none

module tb_ysyx_22040750_axi_refill;

`ifdef YSYX_22040750_RLAST_CHECK_EN
   localparam bit ERR_EN = 1'b1;
`else
   localparam bit ERR_EN = 1'b0;
`endif

   typedef struct {
      logic [255:0] line;
      logic         err;
      int           cyc;
   } done_t;

   logic clk = 1'b0;
   logic rst = 1'b1;
   int   cyc = 0;
   int   n_tests = 0;
   int   n_fail = 0;

   logic [31:0] ar_q[$];
   done_t       done_q[$];

   logic        stall_prev = 1'b0;
   logic [31:0] stall_addr = '0;

   ysyx_22040750_axi_refill_if #(.LINE_BEATS(4)) bus ();

   ysyx_22040750_axi_refill #(
      .LINE_BEATS (4),
      .OFS_W      (5)
   ) dut (
      .I_clk (clk),
      .I_rst (rst),
      .bus   (bus.master)
   );

   always #5 clk = ~clk;
   always @(posedge clk) cyc <= cyc + 1;

   task automatic check(input string nm, input logic [255:0] act, input logic [255:0] exp);
      n_tests++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %h expected %h", nm, act, exp);
      end
   endtask

   // Monitor: pops expectations whenever the DUT presents an AR handshake or done.
   always @(negedge clk) begin
      if (rst) begin
         stall_prev = 1'b0;
      end else begin
         if (stall_prev) begin
            check("ar_stall_valid", {255'd0, bus.arvalid}, 256'd1);
            check("ar_stall_addr", {224'd0, bus.araddr}, {224'd0, stall_addr});
         end
         stall_prev = 1'b0;
         if (bus.arvalid) begin
            if (bus.arready) begin
               if (ar_q.size() == 0) begin
                  check("ar_unexpected", 256'd1, 256'd0);
               end else begin
                  check("araddr", {224'd0, bus.araddr}, {224'd0, ar_q.pop_front()});
                  check("arlen", {248'd0, bus.arlen}, 256'd3);
                  check("arsize", {253'd0, bus.arsize}, 256'd3);
               end
            end else begin
               stall_prev = 1'b1;
               stall_addr = bus.araddr;
            end
         end
         if (bus.done) begin
            if (done_q.size() == 0) begin
               check("done_unexpected", 256'd1, 256'd0);
            end else begin
               done_t e;
               e = done_q.pop_front();
               check("done_line", bus.line_data, e.line);
               check("done_err", {255'd0, bus.err}, {255'd0, e.err});
               if (e.cyc >= 0) check("done_cycle", 256'(cyc), 256'(e.cyc));
            end
         end
      end
   end

   task automatic request(input logic [31:0] a, output int t0);
      bus.req_valid = 1'b1;
      bus.req_addr  = a;
      for (int i = 0; i < 20 && !bus.req_ready; i++) @(posedge clk) #1;
      check("req_ready_wait", {255'd0, bus.req_ready}, 256'd1);
      t0 = cyc;
      @(posedge clk) #1;
   endtask

   task automatic serve_ar(input int ar_wait);
      for (int i = 0; i < 20 && !bus.arvalid; i++) @(posedge clk) #1;
      check("ar_timeout", {255'd0, bus.arvalid}, 256'd1);
      for (int i = 0; i < ar_wait; i++) begin
         check("req_ready_in_ar", {255'd0, bus.req_ready}, 256'd0);
         @(posedge clk) #1;
      end
      bus.arready = 1'b1;
      @(posedge clk) #1;
      bus.arready = 1'b0;
   endtask

   task automatic serve_r(input logic [63:0] d[8], input int n, input int last_at, input bit toggle);
      for (int i = 0; i < n; i++) begin
         if (toggle && i > 0) begin
            bus.rvalid = 1'b0;
            @(posedge clk) #1;
         end
         bus.rvalid = 1'b1;
         bus.rdata  = d[i];
         bus.rlast  = (i == last_at);
         @(posedge clk) #1;
      end
      bus.rvalid = 1'b0;
      bus.rlast  = 1'b0;
   endtask

   task automatic reset_dut();
      rst = 1'b1;
      repeat (2) @(posedge clk);
      #1 rst = 1'b0;
   endtask

   initial begin
      #200000;
      $display("FAIL global_timeout: got running expected finished");
      $fatal(1, "timeout");
   end

   initial begin
      logic [63:0] d[8];
      int t0;
      bus.req_valid = 1'b0;
      bus.req_addr  = '0;
      bus.arready   = 1'b0;
      bus.rdata     = '0;
      bus.rvalid    = 1'b0;
      bus.rlast     = 1'b0;
      repeat (3) @(posedge clk);
      #1 rst = 1'b0;

      check("rst_req_ready", {255'd0, bus.req_ready}, 256'd1);
      check("rst_done", {255'd0, bus.done}, 256'd0);
      check("rst_arvalid", {255'd0, bus.arvalid}, 256'd0);
      check("rst_rready", {255'd0, bus.rready}, 256'd0);
      check("rst_err", {255'd0, bus.err}, 256'd0);
      check("rst_line", bus.line_data, 256'd0);
      check("rst_araddr", {224'd0, bus.araddr}, 256'd0);

      // Zero-wait refill.
      d = '{64'h1111111111111111, 64'h2222222222222222, 64'h3333333333333333,
            64'h4444444444444444, 0, 0, 0, 0};
      ar_q.push_back(32'h8000_0000);
      bus.req_valid = 1'b1;
      bus.req_addr  = 32'h8000_0014;
      t0 = cyc;
      done_q.push_back('{256'h4444444444444444_3333333333333333_2222222222222222_1111111111111111, 1'b0, t0 + 6});
      @(posedge clk) #1;
      bus.req_valid = 1'b0;
      check("zw_arvalid_c1", {255'd0, bus.arvalid}, 256'd1);
      serve_ar(0);
      serve_r(d, 4, 3, 1'b0);
      repeat (3) @(posedge clk);
      #1;

      // Backpressure on AR and gapped R.
      d = '{64'h0123456789ABCDEF, 64'hFEDCBA9876543210, 64'hDEADBEEF00000001,
            64'hCAFEF00D00000002, 0, 0, 0, 0};
      ar_q.push_back(32'h0000_1FE0);
      done_q.push_back('{256'hCAFEF00D00000002_DEADBEEF00000001_FEDCBA9876543210_0123456789ABCDEF, 1'b0, -1});
      request(32'h0000_1FFF, t0);
      bus.req_valid = 1'b0;
      serve_ar(3);
      serve_r(d, 4, 3, 1'b1);
      repeat (3) @(posedge clk);
      #1;

      // Back-to-back with the second request held during the first burst.
      d = '{64'h5555555555555555, 64'h6666666666666666, 64'h7777777777777777,
            64'h8888888888888888, 0, 0, 0, 0};
      ar_q.push_back(32'h1000_0020);
      ar_q.push_back(32'h8000_0040);
      done_q.push_back('{256'h8888888888888888_7777777777777777_6666666666666666_5555555555555555, 1'b0, -1});
      done_q.push_back('{256'hCCCCCCCCCCCCCCCC_BBBBBBBBBBBBBBBB_AAAAAAAAAAAAAAAA_9999999999999999, 1'b0, -1});
      request(32'h1000_0028, t0);
      bus.req_addr = 32'h8000_0040;
      check("b2b_ready_ar", {255'd0, bus.req_ready}, 256'd0);
      serve_ar(1);
      serve_r(d, 4, 3, 1'b0);
      check("b2b_ready_done", {255'd0, bus.req_ready}, 256'd0);
      check("b2b_done_now", {255'd0, bus.done}, 256'd1);
      @(posedge clk) #1;
      check("b2b_ready_idle", {255'd0, bus.req_ready}, 256'd1);
      request(32'h8000_0040, t0);
      bus.req_valid = 1'b0;
      serve_ar(0);
      check("b2b_line_hold", bus.line_data,
            256'h8888888888888888_7777777777777777_6666666666666666_5555555555555555);
      d = '{64'h9999999999999999, 64'hAAAAAAAAAAAAAAAA, 64'hBBBBBBBBBBBBBBBB,
            64'hCCCCCCCCCCCCCCCC, 0, 0, 0, 0};
      serve_r(d, 4, 3, 1'b0);
      repeat (3) @(posedge clk);
      #1;

      // Reset after two beats abandons the burst.
      d = '{64'hD0D0D0D0D0D0D0D0, 64'hD1D1D1D1D1D1D1D1, 0, 0, 0, 0, 0, 0};
      ar_q.push_back(32'hFFFF_FFE0);
      request(32'hFFFF_FFFF, t0);
      bus.req_valid = 1'b0;
      serve_ar(0);
      serve_r(d, 2, -1, 1'b0);
      rst = 1'b1;
      @(posedge clk) #1;
      rst = 1'b0;
      check("mid_rst_ready", {255'd0, bus.req_ready}, 256'd1);
      check("mid_rst_rready", {255'd0, bus.rready}, 256'd0);
      check("mid_rst_line", bus.line_data, 256'd0);
      check("mid_rst_done", {255'd0, bus.done}, 256'd0);
      repeat (4) @(posedge clk);
      #1;

      // Missing rlast: six beats, rlast only on the sixth.
      d = '{64'hA0A0A0A0A0A0A0A0, 64'hA1A1A1A1A1A1A1A1, 64'hA2A2A2A2A2A2A2A2,
            64'hA3A3A3A3A3A3A3A3, 64'hA4A4A4A4A4A4A4A4, 64'hA5A5A5A5A5A5A5A5, 0, 0};
      ar_q.push_back(32'h2000_0000);
      if (ERR_EN)
         done_q.push_back('{256'hA3A3A3A3A3A3A3A3_A2A2A2A2A2A2A2A2_A1A1A1A1A1A1A1A1_A0A0A0A0A0A0A0A0, 1'b1, -1});
      else
         done_q.push_back('{256'hA5A5A5A5A5A5A5A5_A2A2A2A2A2A2A2A2_A1A1A1A1A1A1A1A1_A0A0A0A0A0A0A0A0, 1'b0, -1});
      request(32'h2000_0004, t0);
      bus.req_valid = 1'b0;
      serve_ar(0);
      serve_r(d, 6, 5, 1'b0);
      repeat (3) @(posedge clk);
      reset_dut();
      check("err_cleared", {255'd0, bus.err}, 256'd0);

      // Early rlast on beat 2 of 4.
      d = '{64'hC0C0C0C0C0C0C0C0, 64'hC1C1C1C1C1C1C1C1, 0, 0, 0, 0, 0, 0};
      ar_q.push_back(32'h3000_0020);
      done_q.push_back('{256'h0000000000000000_0000000000000000_C1C1C1C1C1C1C1C1_C0C0C0C0C0C0C0C0, ERR_EN, -1});
      request(32'h3000_003F, t0);
      bus.req_valid = 1'b0;
      serve_ar(0);
      serve_r(d, 2, 1, 1'b0);
      repeat (4) @(posedge clk);
      #1;
      check("early_err_sticky", {255'd0, bus.err}, {255'd0, ERR_EN});

      check("ar_q_drained", 256'(ar_q.size()), 256'd0);
      check("done_q_drained", 256'(done_q.size()), 256'd0);
      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule

`default_nettype wire
